// File: rtl/seg_display_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// seg_pkg
// Shared definitions for the seven-segment display arbiter:
//   - NUM_REQ : number of requesters sharing the display
//   - state_t : arbiter FSM states (IDLE / SHOW / BLANK)
//   - onehot3 : 2-bit index -> 3-bit one-hot grant vector
//   - add_mod3: modulo-3 addition used for the round-robin pointer
// ---------------------------------------------------------------------------
package seg_pkg;

  localparam int NUM_REQ = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_BLANK = 2'd2
  } state_t;

  function automatic logic [NUM_REQ-1:0] onehot3(input logic [1:0] i);
    logic [NUM_REQ-1:0] r;
    case (i)
      2'd0:    r = 3'b001;
      2'd1:    r = 3'b010;
      2'd2:    r = 3'b100;
      default: r = 3'b000;
    endcase
    return r;
  endfunction

  // Operands are expected in 0..2; any sum up to 5 still folds into 0..2.
  function automatic logic [1:0] add_mod3(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 3'd3) begin
      s = s - 3'd3;
    end
    return s[1:0];
  endfunction

endpackage

// File: rtl/seg_display_arbiter_if.sv
// ---------------------------------------------------------------------------
// seg_display_arbiter_if
// Bundles the requester side (req, data0..2, blink) and the display side
// (num, idle, grant) of the arbiter.
//   master : the requesters / environment (drives req, data, blink)
//   slave  : the arbiter (drives num, idle, grant)
// ---------------------------------------------------------------------------
interface seg_display_arbiter_if;
  import seg_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic [7:0]         data0;
  logic [7:0]         data1;
  logic [7:0]         data2;
  logic [NUM_REQ-1:0] blink;
  logic [7:0]         num;
  logic               idle;
  logic [NUM_REQ-1:0] grant;

  modport master (
    output req, data0, data1, data2, blink,
    input  num, idle, grant
  );

  modport slave (
    input  req, data0, data1, data2, blink,
    output num, idle, grant
  );

endinterface

// File: rtl/seg_display_arbiter_rr_pick3.sv
// ---------------------------------------------------------------------------
// rr_pick3
// Combinational round-robin picker over three requesters. Searches
// ptr, ptr+1, ptr+2 (mod 3); the first index with req set wins.
//   req   [2:0] in  : request vector
//   ptr   [1:0] in  : search start index (0..2)
//   valid       out : at least one request present
//   idx   [1:0] out : winning requester index
// ---------------------------------------------------------------------------
module rr_pick3
  import seg_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         ptr,
  output logic               valid,
  output logic [1:0]         idx
);

  logic [1:0] cand [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      assign cand[gi] = add_mod3(ptr, 2'(gi));
    end
  endgenerate

  // Walk from the farthest candidate back to ptr so the nearest hit is
  // the last assignment and therefore wins.
  always_comb begin
    valid = 1'b0;
    idx   = 2'd0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[cand[k]]) begin
        valid = 1'b1;
        idx   = cand[k];
      end
    end
  end

endmodule

// File: rtl/seg_display_arbiter.sv
// ---------------------------------------------------------------------------
// seg_display_arbiter
// Shares one 2-digit seven-segment multiplexer among three requesters.
// Round-robin ownership with a minimum hold time, a blank gap between
// owners and per-requester blinking via the idle output.
//   CLK    in  : system clock, all logic on posedge
//   reset  in  : synchronous active-high reset
//   bus    slave modport:
//     req[2:0], data0..2[7:0], blink[2:0]  in
//     num[7:0], idle, grant[2:0]           out (all registered)
// ---------------------------------------------------------------------------
module seg_display_arbiter
  import seg_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES  = 100000000,
  parameter int unsigned GAP_CYCLES   = 5000000,
  parameter int unsigned BLINK_CYCLES = 25000000,
  parameter int unsigned CNT_W        = 27
) (
  input  logic                  CLK,
  input  logic                  reset,
  seg_display_arbiter_if.slave  bus
);

  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_CYCLES - 1);

  state_t             state_reg,       state_next;
  logic [1:0]         owner_reg,       owner_next;
  logic [1:0]         ptr_reg,         ptr_next;
  logic [CNT_W-1:0]   hold_cnt_reg,    hold_cnt_next;
  logic [CNT_W-1:0]   gap_cnt_reg,     gap_cnt_next;
  logic [CNT_W-1:0]   blink_cnt_reg,   blink_cnt_next;
  logic               blink_phase_reg, blink_phase_next;
  logic [7:0]         num_reg,         num_next;
  logic               idle_reg,        idle_next;
  logic [NUM_REQ-1:0] grant_reg,       grant_next;

  logic               pick_valid;
  logic [1:0]         pick_idx;
  logic [NUM_REQ-1:0] owner_mask;
  logic               owner_req;
  logic               other_req;
  logic               owner_blink;

  function automatic logic [7:0] sel_data(input logic [1:0] i,
                                          input logic [7:0] d0,
                                          input logic [7:0] d1,
                                          input logic [7:0] d2);
    logic [7:0] r;
    case (i)
      2'd1:    r = d1;
      2'd2:    r = d2;
      default: r = d0;
    endcase
    return r;
  endfunction

  // Single picker shared by the IDLE and BLANK exits.
  rr_pick3 u_pick (
    .req   (bus.req),
    .ptr   (ptr_reg),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign owner_mask  = onehot3(owner_reg);
  assign owner_req   = |(bus.req & owner_mask);
  assign other_req   = |(bus.req & ~owner_mask);
  assign owner_blink = |(bus.blink & owner_mask);

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      owner_reg       <= 2'd0;
      ptr_reg         <= 2'd0;
      hold_cnt_reg    <= '0;
      gap_cnt_reg     <= '0;
      blink_cnt_reg   <= '0;
      blink_phase_reg <= 1'b0;
      num_reg         <= 8'h00;
      idle_reg        <= 1'b1;
      grant_reg       <= '0;
    end else begin
      state_reg       <= state_next;
      owner_reg       <= owner_next;
      ptr_reg         <= ptr_next;
      hold_cnt_reg    <= hold_cnt_next;
      gap_cnt_reg     <= gap_cnt_next;
      blink_cnt_reg   <= blink_cnt_next;
      blink_phase_reg <= blink_phase_next;
      num_reg         <= num_next;
      idle_reg        <= idle_next;
      grant_reg       <= grant_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    owner_next       = owner_reg;
    ptr_next         = ptr_reg;
    hold_cnt_next    = hold_cnt_reg;
    gap_cnt_next     = gap_cnt_reg;
    blink_cnt_next   = blink_cnt_reg;
    blink_phase_next = blink_phase_reg;
    num_next         = num_reg;
    idle_next        = idle_reg;
    grant_next       = grant_reg;

    case (state_reg)
      ST_IDLE: begin
        idle_next  = 1'b1;
        grant_next = '0;
        if (pick_valid) begin
          state_next       = ST_SHOW;
          owner_next       = pick_idx;
          grant_next       = onehot3(pick_idx);
          idle_next        = 1'b0;
          num_next         = sel_data(pick_idx, bus.data0, bus.data1, bus.data2);
          hold_cnt_next    = '0;
          blink_cnt_next   = '0;
          blink_phase_next = 1'b0;
        end
      end

      ST_SHOW: begin
        num_next      = sel_data(owner_reg, bus.data0, bus.data1, bus.data2);
        hold_cnt_next = hold_cnt_reg + CNT_W'(1);

        if (blink_cnt_reg == BLINK_LAST) begin
          blink_cnt_next   = '0;
          blink_phase_next = ~blink_phase_reg;
        end else begin
          blink_cnt_next   = blink_cnt_reg + CNT_W'(1);
        end
        // Registered idle reflects the phase that is current in the cycle
        // it is displayed, so use the post-toggle phase.
        idle_next = owner_blink & blink_phase_next;

        // A dropped request releases the display even on the hold-expiry
        // cycle; expiry with nobody else waiting just restarts the hold.
        if (!owner_req || ((hold_cnt_reg == HOLD_LAST) && other_req)) begin
          state_next   = ST_BLANK;
          ptr_next     = add_mod3(owner_reg, 2'd1);
          grant_next   = '0;
          idle_next    = 1'b1;
          gap_cnt_next = '0;
        end else if (hold_cnt_reg == HOLD_LAST) begin
          hold_cnt_next = '0;
        end
      end

      ST_BLANK: begin
        idle_next  = 1'b1;
        grant_next = '0;
        if (gap_cnt_reg == GAP_LAST) begin
          gap_cnt_next = '0;
          if (pick_valid) begin
            state_next       = ST_SHOW;
            owner_next       = pick_idx;
            grant_next       = onehot3(pick_idx);
            idle_next        = 1'b0;
            num_next         = sel_data(pick_idx, bus.data0, bus.data1, bus.data2);
            hold_cnt_next    = '0;
            blink_cnt_next   = '0;
            blink_phase_next = 1'b0;
          end else begin
            state_next = ST_IDLE;
          end
        end else begin
          gap_cnt_next = gap_cnt_reg + CNT_W'(1);
        end
      end

      default: begin
        state_next = ST_IDLE;
        idle_next  = 1'b1;
        grant_next = '0;
      end
    endcase
  end

  assign bus.num   = num_reg;
  assign bus.idle  = idle_reg;
  assign bus.grant = grant_reg;

endmodule

// File: tb/tb_seg_display_arbiter.sv
module tb_seg_display_arbiter;

  logic CLK = 1'b0;
  logic reset;

  always #5 CLK = ~CLK;

  seg_display_arbiter_if bus();

  seg_display_arbiter #(
    .HOLD_CYCLES  (8),
    .GAP_CYCLES   (2),
    .BLINK_CYCLES (3),
    .CNT_W        (4)
  ) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int         due;
    logic [2:0] g;
    logic       i;
    logic [7:0] n;
    bit         chk_n;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   n_cmp  = 0;
  int   n_bad  = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Monitor: after every edge, retire the expectations due for this edge.
  always @(posedge CLK) begin
    cyc++;
    #2;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      chk({e.tag, ".grant"}, {5'd0, bus.grant}, {5'd0, e.g});
      chk({e.tag, ".idle"},  {7'd0, bus.idle},  {7'd0, e.i});
      if (e.chk_n) chk({e.tag, ".num"}, bus.num, e.n);
      $display("cyc=%0d %s grant=%b idle=%b num=%h", cyc, e.tag, bus.grant, bus.idle, bus.num);
    end
  end

  // Inputs are already set; record what the outputs must be after the
  // next edge, then advance to just past that edge.
  task automatic step(input logic [2:0] g, input logic i, input logic [7:0] n,
                      input bit chk_n, input string tag);
    exp_t e;
    e.due = cyc + 1; e.g = g; e.i = i; e.n = n; e.chk_n = chk_n; e.tag = tag;
    sb.push_back(e);
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.req = 3'b000;
    bus.blink = 3'b000;
    step(3'b000, 1'b1, 8'h00, 1'b1, "rst");
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.req = 3'b000;
    bus.blink = 3'b000;
    bus.data0 = 8'h11;
    bus.data1 = 8'h22;
    bus.data2 = 8'h33;
    @(posedge CLK);
    #1;

    // 1: no requests -> blank and idle
    do_reset();
    repeat (20) step(3'b000, 1'b1, 8'h00, 1'b1, "t1_idle");

    // 2: single requester keeps the display past hold expiry
    do_reset();
    bus.data1 = 8'h42;
    bus.req = 3'b010;
    step(3'b010, 1'b0, 8'h42, 1'b1, "t2_first");
    repeat (29) step(3'b010, 1'b0, 8'h42, 1'b1, "t2_hold");

    // 3: two requesters rotate with an 8-cycle hold and 2-cycle gap
    do_reset();
    bus.data0 = 8'h11;
    bus.data1 = 8'h22;
    bus.req = 3'b011;
    repeat (8) step(3'b001, 1'b0, 8'h11, 1'b1, "t3_own0a");
    repeat (2) step(3'b000, 1'b1, 8'h11, 1'b1, "t3_gap0");
    repeat (8) step(3'b010, 1'b0, 8'h22, 1'b1, "t3_own1");
    repeat (2) step(3'b000, 1'b1, 8'h22, 1'b1, "t3_gap1");
    repeat (8) step(3'b001, 1'b0, 8'h11, 1'b1, "t3_own0b");

    // 4: owner drops request mid-hold; gap then requester 2
    do_reset();
    bus.req = 3'b001;
    repeat (4) step(3'b001, 1'b0, 8'h11, 1'b1, "t4_own0");
    bus.req = 3'b100;
    repeat (2) step(3'b000, 1'b1, 8'h11, 1'b1, "t4_gap");
    repeat (3) step(3'b100, 1'b0, 8'h33, 1'b1, "t4_own2");

    // 5: blinking with half-period 3, then blink cleared
    do_reset();
    bus.data0 = 8'h55;
    bus.req = 3'b001;
    bus.blink = 3'b001;
    step(3'b001, 1'b0, 8'h55, 1'b1, "t5_b0");
    step(3'b001, 1'b0, 8'h55, 1'b1, "t5_b1");
    step(3'b001, 1'b0, 8'h55, 1'b1, "t5_b2");
    step(3'b001, 1'b1, 8'h55, 1'b1, "t5_b3");
    step(3'b001, 1'b1, 8'h55, 1'b1, "t5_b4");
    step(3'b001, 1'b1, 8'h55, 1'b1, "t5_b5");
    step(3'b001, 1'b0, 8'h55, 1'b1, "t5_b6");
    step(3'b001, 1'b0, 8'h55, 1'b1, "t5_b7");
    step(3'b001, 1'b0, 8'h55, 1'b1, "t5_b8");
    step(3'b001, 1'b1, 8'h55, 1'b1, "t5_b9");
    bus.blink = 3'b000;
    repeat (3) step(3'b001, 1'b0, 8'h55, 1'b1, "t5_off");

    // 6: reset mid-BLANK and mid-SHOW restarts from requester 0
    do_reset();
    bus.data0 = 8'h11;
    bus.req = 3'b011;
    repeat (8) step(3'b001, 1'b0, 8'h11, 1'b1, "t6_own0");
    step(3'b000, 1'b1, 8'h11, 1'b1, "t6_gap");
    reset = 1'b1;
    step(3'b000, 1'b1, 8'h00, 1'b1, "t6_rst_blank");
    reset = 1'b0;
    repeat (8) step(3'b001, 1'b0, 8'h11, 1'b1, "t6_after_rb");
    repeat (2) step(3'b000, 1'b1, 8'h11, 1'b1, "t6_gap2");
    repeat (3) step(3'b010, 1'b0, 8'h22, 1'b1, "t6_own1");
    reset = 1'b1;
    step(3'b000, 1'b1, 8'h00, 1'b1, "t6_rst_show");
    reset = 1'b0;
    repeat (2) step(3'b001, 1'b0, 8'h11, 1'b1, "t6_after_rs");

    repeat (2) @(posedge CLK);
    #3;
    n_cmp++;
    assert (sb.size() == 0) else begin
      n_bad++;
      $error("FAIL sb_drain observed=%0d expected=0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
